div_seq_param: RTL and testbench
================================

Name: div_seq_param

Overview:
- Parametrised multi-cycle integer divider for the MIPS datapath. It serves DIV/DIVU and feeds HI (remainder) and LO (quotient).
- Successor to the fixed 32-bit divider. Adds a WIDTH parameter, a start/busy/done handshake, fixed latency, defined divide-by-zero and signed-overflow results, and a status flag.
- One radix-2 restoring iteration per clock.

Parameters:
- WIDTH, 32: operand, quotient and remainder width in bits. Must be at least 4.
- CNT_W, $clog2(WIDTH): width of the iteration counter (derived; do not override).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- divrst_n  in  1  asynchronous active-low reset. Assertion clears all state at once; deassertion is synchronised externally.
- start  in  1  request pulse; sampled only in IDLE.
- signdiv  in  1  1 = signed (DIV), 0 = unsigned (DIVU); captured with start.
- a  in  WIDTH  dividend; captured with start.
- b  in  WIDTH  divisor; captured with start.
- busy  out  1  high from the edge that accepts start until done deasserts.
- done  out  1  one-cycle pulse; q, r and dbz are valid in that cycle.
- q  out  WIDTH  quotient; registered, held until the next completion.
- r  out  WIDTH  remainder; registered, held until the next completion.
- dbz  out  1  divide-by-zero flag for the last completed operation; held like q and r.

Behaviour:
- Reset: state=IDLE; busy, done, dbz = 0; q, r = 0; internal registers = 0. Asserting reset mid-operation aborts the operation, and no done is produced.
- States:
  - IDLE: on start=1, capture a, b and signdiv; go to PREP.
  - PREP: form magnitudes. In signed mode take the two's-complement absolute value when the MSB is set. Record qneg = sa XOR sb and rneg = sa. Record zero = (b==0). Set rem=0, quo=|a|, cnt=WIDTH-1. Go to ITER.
  - ITER: one restoring step per cycle. Shift {rem,quo} left by 1; trial = rem_shifted - |b| at WIDTH+1 bits. If trial is non-negative, rem = trial and set the new quo LSB to 1; otherwise keep rem_shifted and set the LSB to 0. Go to FIX when cnt==0; otherwise decrement cnt.
  - FIX: apply signs. q = qneg ? -quo : quo; r = rneg ? -rem : rem. Go to DONE.
  - DONE: done=1 for exactly one cycle; then IDLE.
- Latency:
  - If start is sampled at edge k, q, r and dbz update and done rises at edge k+WIDTH+3. done falls at edge k+WIDTH+4.
  - Latency is fixed and independent of operand values, including the zero divisor.
- busy is high from edge k through the edge that clears done.
- start while busy is ignored; it is neither queued nor flagged. start in the DONE cycle is also ignored.
- A new start may be accepted in the first IDLE cycle after DONE. Back-to-back throughput is one operation per WIDTH+4 cycles.
- Operand changes on a, b or signdiv after the accepting edge have no effect.
- Unsigned semantics: q = floor(a/b), r = a - q*b.
- Signed semantics: truncate toward zero; remainder takes the sign of the dividend; |r| < |b|.
- Divide by zero (b==0):
  - Restoring iteration runs unchanged, giving quo = all ones and rem = |a|.
  - Sign fix still applies, so unsigned gives q = all ones, r = a. Signed gives q = qneg ? 1 : all ones, r = a.
  - dbz = 1. The results are defined so the bench can check them; the ISA treats them as undefined.
- Signed overflow (a = most-negative, b = -1): q = most-negative value (wrap), r = 0, dbz = 0.
- Magnitude of the most-negative value: treat as the unsigned 2^(WIDTH-1), which is correct in WIDTH bits. No extra bit is needed on quo.
- Outputs are registered; nothing combinational goes from inputs to outputs.

Decomposition:
- Shared package div_pkg:
  - state enum div_state_t {IDLE, PREP, ITER, FIX, DONE}.
  - Function abs_w for the signed magnitude.
  - Constant DIV_LATENCY = WIDTH+3, for bench use.
- Sub-module div_step: combinational single restoring step, parametrised by WIDTH.
  - Inputs: rem, quo, divisor magnitude.
  - Outputs: next rem, next quo.
  - Instantiated once in ITER; unit-testable separately.

Test Plan:
- WIDTH=32, unsigned: a=FFFFFFFF, b=00000001, start at edge k -> done at k+35, q=FFFFFFFF, r=00000000, dbz=0, busy high k..k+35.
- Signed: a=FFFFFFF9 (-7), b=00000002 -> q=FFFFFFFD (-3), r=FFFFFFFF (-1). Unsigned with the same operands -> q=7FFFFFFC, r=00000001.
- b=0 with a=00000005:
  - unsigned -> q=FFFFFFFF, r=00000005, dbz=1.
  - signed a=FFFFFFFB -> q=00000001, r=FFFFFFFB, dbz=1.
- Signed a=80000000, b=FFFFFFFF -> q=80000000, r=0, dbz=0. Next start with a=10, b=3 -> q=3, r=1, dbz=0.
- Handshake and reset:
  - start re-pulsed at k+5 with different operands -> ignored; results match the first operation.
  - divrst_n low at k+10 -> busy=0 and q=r=0 immediately; no done pulse.
  - A new start after release completes normally.
- WIDTH=8 instance, 500 random operand pairs plus signdiv -> every result matches the reference model. done occurs exactly WIDTH+3 edges after start.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM states,
// signed-magnitude helper and the fixed start-to-done latency.
package div_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIX,
        DONE
    } div_state_t;

    // Widest operand the magnitude helper supports.
    localparam int MAX_W       = 128;
    localparam int DEF_WIDTH   = 32;
    localparam int DIV_LATENCY = DEF_WIDTH + 3;

    function automatic int div_latency(input int w);
        return w + 3;
    endfunction

    // The caller supplies the sign bit; the most-negative value comes back
    // as 2^(w-1), which is exact in the low w bits.
    function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] v,
                                               input logic             neg);
        return neg ? (~v + MAX_W'(1)) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift {rem,quo} left and subtract the
// divisor magnitude when it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dmag,
    output logic [WIDTH-1:0] rem_nxt,
    output logic [WIDTH-1:0] quo_nxt
);

    logic [WIDTH:0]   sh;
    logic [WIDTH-1:0] trial;

    assign sh = {rem, quo[WIDTH-1]};
    // Only used when sh >= dmag, so the difference always fits in WIDTH bits.
    assign trial = sh[WIDTH-1:0] - dmag;

    always_comb begin
        rem_nxt = sh[WIDTH-1:0];
        quo_nxt = {quo[WIDTH-2:0], 1'b0};
        if (sh >= {1'b0, dmag}) begin
            rem_nxt = trial;
            quo_nxt = {quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_seq_param.sv
// Multi-cycle signed/unsigned integer divider with start/busy/done handshake
// and fixed WIDTH+3 cycle latency; q/r/dbz are registered and held.
module div_seq_param
    import div_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             divrst_n,
    input  logic             start,
    input  logic             signdiv,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             dbz
);

    // state | meaning
    // IDLE  | waiting for start; operands captured on start
    // PREP  | form magnitudes, sign flags and zero-divisor flag
    // ITER  | one restoring step per cycle, WIDTH cycles
    // FIX   | apply result signs to quotient and remainder
    // DONE  | publish q/r/dbz and pulse done on the next edge
    div_state_t state, state_nxt;

    logic [WIDTH-1:0] a_r, b_r, bmag, rem, quo;
    logic [WIDTH-1:0] a_mag, b_mag, rem_nxt, quo_nxt;
    logic [CNT_W-1:0] cnt;
    logic             sgn_r, qneg, rneg, zero;
    logic             sa, sb;

    assign sa    = sgn_r & a_r[WIDTH-1];
    assign sb    = sgn_r & b_r[WIDTH-1];
    assign a_mag = WIDTH'(abs_w(MAX_W'(a_r), sa));
    assign b_mag = WIDTH'(abs_w(MAX_W'(b_r), sb));

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem),
        .quo     (quo),
        .dmag    (bmag),
        .rem_nxt (rem_nxt),
        .quo_nxt (quo_nxt)
    );

    always_ff @(posedge clk or negedge divrst_n) begin
        if (!divrst_n) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = PREP;
            PREP:    state_nxt = ITER;
            ITER:    if (cnt == '0) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge divrst_n) begin
        if (!divrst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            sgn_r <= 1'b0;
            bmag  <= '0;
            rem   <= '0;
            quo   <= '0;
            cnt   <= '0;
            qneg  <= 1'b0;
            rneg  <= 1'b0;
            zero  <= 1'b0;
            q     <= '0;
            r     <= '0;
            dbz   <= 1'b0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            done <= (state == DONE);
            // A start accepted on the edge that clears done keeps busy high.
            if (state == IDLE && start) busy <= 1'b1;
            else if (done)              busy <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        sgn_r <= signdiv;
                    end
                end
                PREP: begin
                    rem  <= '0;
                    quo  <= a_mag;
                    bmag <= b_mag;
                    qneg <= sa ^ sb;
                    rneg <= sa;
                    zero <= (b_r == '0);
                    cnt  <= CNT_W'(WIDTH - 1);
                end
                ITER: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    if (cnt != '0) cnt <= cnt - CNT_W'(1);
                end
                FIX: begin
                    quo <= qneg ? -quo : quo;
                    rem <= rneg ? -rem : rem;
                end
                DONE: begin
                    q   <= quo;
                    r   <= rem;
                    dbz <= zero;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_param.sv
// Bench for div_seq_param: a 32-bit instance with directed vectors and a
// random 8-bit instance, both tracked cycle by cycle against an arithmetic model.
module tb_div_seq_param;
    import div_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic run_chk;
    always #5 clk = ~clk;

    logic        start_v [2];
    logic        sgn_v   [2];
    logic [31:0] a_v     [2];
    logic [31:0] b_v     [2];
    logic        busy_v  [2];
    logic        done_v  [2];
    logic        dbz_v   [2];
    logic [31:0] q_v     [2];
    logic [31:0] r_v     [2];
    logic [7:0]  q8, r8;

    int errors = 0;
    int checks = 0;

    div_seq_param #(.WIDTH(32)) dut32 (
        .clk(clk), .divrst_n(rst_n), .start(start_v[0]), .signdiv(sgn_v[0]),
        .a(a_v[0]), .b(b_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .q(q_v[0]), .r(r_v[0]), .dbz(dbz_v[0])
    );

    div_seq_param #(.WIDTH(8)) dut8 (
        .clk(clk), .divrst_n(rst_n), .start(start_v[1]), .signdiv(sgn_v[1]),
        .a(a_v[1][7:0]), .b(b_v[1][7:0]), .busy(busy_v[1]), .done(done_v[1]),
        .q(q8), .r(r8), .dbz(dbz_v[1])
    );

    assign q_v[1] = {24'h0, q8};
    assign r_v[1] = {24'h0, r8};

    function automatic int wid(input int i);
        return (i == 0) ? 32 : 8;
    endfunction

    // Truncating division on plain integers; b==0 gives the defined
    // all-ones/one quotient and the dividend as remainder.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    input logic s, input int w,
                                    output logic [31:0] q, output logic [31:0] r);
        longint msk, half, ua, ub, sa, sb, qq, rr;
        msk  = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(a) & msk;
        ub   = longint'(b) & msk;
        sa   = (s && ua >= half) ? ua - (msk + 1) : ua;
        sb   = (s && ub >= half) ? ub - (msk + 1) : ub;
        if (ub == 0) begin
            qq = (s && sa < 0) ? 1 : msk;
            rr = ua;
        end else if (s) begin
            qq = sa / sb;
            rr = sa % sb;
        end else begin
            qq = ua / ub;
            rr = ua % ub;
        end
        q = 32'(qq & msk);
        r = 32'(rr & msk);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: an operation accepted at edge k publishes at k+W+3 and frees the
    // divider at k+W+4; starts while occupied are dropped.
    int          edge_cnt = 0;
    bit          m_active [2];
    int          m_acc    [2];
    logic [31:0] m_q [2], m_r [2], p_q [2], p_r [2];
    logic        m_dbz [2], p_dbz [2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_active[i] = 1'b0;
                m_q[i] = '0; m_r[i] = '0; m_dbz[i] = 1'b0;
            end
        end else begin
            edge_cnt++;
            for (int i = 0; i < 2; i++) begin
                logic [31:0] tq, tr, msk;
                if (m_active[i] && edge_cnt == m_acc[i] + wid(i) + 3) begin
                    m_q[i] = p_q[i]; m_r[i] = p_r[i]; m_dbz[i] = p_dbz[i];
                end
                if (m_active[i] && edge_cnt == m_acc[i] + wid(i) + 4)
                    m_active[i] = 1'b0;
                if (start_v[i] && !m_active[i]) begin
                    m_active[i] = 1'b1;
                    m_acc[i] = edge_cnt;
                    ref_div(a_v[i], b_v[i], sgn_v[i], wid(i), tq, tr);
                    msk = (wid(i) == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
                    p_q[i] = tq; p_r[i] = tr;
                    p_dbz[i] = ((b_v[i] & msk) == 32'h0);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (run_chk) begin
            for (int i = 0; i < 2; i++) begin
                logic exp_done;
                exp_done = m_active[i] && (edge_cnt == m_acc[i] + wid(i) + 3);
                chk(i == 0 ? "busy32" : "busy8", 32'(busy_v[i]), 32'(m_active[i]));
                chk(i == 0 ? "done32" : "done8", 32'(done_v[i]), 32'(exp_done));
                chk(i == 0 ? "q32"    : "q8",    q_v[i], m_q[i]);
                chk(i == 0 ? "r32"    : "r8",    r_v[i], m_r[i]);
                chk(i == 0 ? "dbz32"  : "dbz8",  32'(dbz_v[i]), 32'(m_dbz[i]));
            end
        end
    end

    task automatic pulse(input int i, input logic [31:0] aa, input logic [31:0] bb,
                         input logic s);
        @(negedge clk);
        a_v[i] = aa; b_v[i] = bb; sgn_v[i] = s; start_v[i] = 1'b1;
        @(negedge clk);
        start_v[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_v[i] && n < 80);
        chk("done_seen", 32'(done_v[i]), 32'h1);
    endtask

    task automatic run32(input string nm, input logic [31:0] aa, input logic [31:0] bb,
                         input logic s, input logic [31:0] eq, input logic [31:0] er,
                         input logic ed);
        int n;
        pulse(0, aa, bb, s);
        wait_done(0, n);
        chk({nm, "_q"}, q_v[0], eq);
        chk({nm, "_r"}, r_v[0], er);
        chk({nm, "_dbz"}, 32'(dbz_v[0]), 32'(ed));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] tq, tr;
        rst_n = 1'b0;
        run_chk = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0; sgn_v[i] = 1'b0; a_v[i] = '0; b_v[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy_v[0]), 32'h0);
        chk("rst_done", 32'(done_v[0]), 32'h0);
        chk("rst_q",    q_v[0], 32'h0);
        chk("rst_r",    r_v[0], 32'h0);
        chk("rst_dbz",  32'(dbz_v[0]), 32'h0);
        rst_n = 1'b1;
        run_chk = 1'b1;

        ref_div(32'hFFFF_FFF9, 32'h2, 1'b1, 32, tq, tr);
        chk("model_sq", tq, 32'hFFFF_FFFD);
        chk("model_sr", tr, 32'hFFFF_FFFF);
        ref_div(32'h80, 32'hFF, 1'b1, 8, tq, tr);
        chk("model_ovf8", tq, 32'h80);
        ref_div(32'h5, 32'h0, 1'b0, 32, tq, tr);
        chk("model_dbz_q", tq, 32'hFFFF_FFFF);
        chk("model_dbz_r", tr, 32'h5);

        pulse(0, 32'hFFFF_FFFF, 32'h1, 1'b0);
        wait_done(0, n);
        chk("lat32", 32'(n), 32'(DIV_LATENCY));
        chk("max_q", q_v[0], 32'hFFFF_FFFF);
        chk("max_r", r_v[0], 32'h0);

        run32("sneg",  32'hFFFF_FFF9, 32'h2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run32("uneg",  32'hFFFF_FFF9, 32'h2, 1'b0, 32'h7FFF_FFFC, 32'h1, 1'b0);
        run32("udbz",  32'h5, 32'h0, 1'b0, 32'hFFFF_FFFF, 32'h5, 1'b1);
        run32("sdbz",  32'hFFFF_FFFB, 32'h0, 1'b1, 32'h1, 32'hFFFF_FFFB, 1'b1);
        run32("ovf",   32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0, 1'b0);
        run32("ten3",  32'd10, 32'd3, 1'b1, 32'd3, 32'd1, 1'b0);

        // Second start (and operand change) while busy must be dropped.
        pulse(0, 32'd100, 32'd7, 1'b0);
        repeat (4) @(negedge clk);
        a_v[0] = 32'd9; b_v[0] = 32'd2; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0, n);
        chk("ign_lat", 32'(n), 32'd30);
        chk("ign_q", q_v[0], 32'd14);
        chk("ign_r", r_v[0], 32'd2);

        // Reset in the middle of an operation.
        pulse(0, 32'd1000, 32'd3, 1'b0);
        repeat (9) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy_v[0]), 32'h0);
        chk("abort_q",    q_v[0], 32'h0);
        chk("abort_r",    r_v[0], 32'h0);
        chk("abort_done", 32'(done_v[0]), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run32("after_rst", 32'd1000, 32'd3, 1'b0, 32'd333, 32'd1, 1'b0);

        // 8-bit instance: back-to-back at the maximum rate of one per WIDTH+4.
        for (int k = 0; k < 500; k++) begin
            logic [31:0] ra, rb;
            ra = $urandom_range(0, 255);
            rb = (k % 25 == 0) ? 32'h0 : 32'($urandom_range(0, 255));
            if (k % 40 == 7) begin
                ra = 32'h80; rb = 32'hFF;
            end
            pulse(1, ra, rb, 1'($urandom_range(0, 1)));
            repeat (div_latency(8) - 1) @(negedge clk);
        end
        repeat (16) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
